// File: rtl/alu_pkg.sv
// Shared widths and the command record for the ALU command queue.
package alu_pkg;

    localparam int ALU_W = 4;
    localparam int SEL_W = 3;

    typedef struct packed {
        logic [ALU_W-1:0] A;
        logic [ALU_W-1:0] B;
        logic [SEL_W-1:0] sel;
        logic             Cin;
    } alu_cmd_t;

endpackage

// File: rtl/alu_cmd_mem.sv
// Command storage: DEPTH entries, one synchronous write port, one asynchronous read port.
module alu_cmd_mem
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  alu_cmd_t      wdata,
    input  logic [AW-1:0] raddr,
    output alu_cmd_t      rdata
);

    // Contents are intentionally left uninitialised; occupancy is tracked by the queue.
    alu_cmd_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/alu_cmd_queue.sv
// FIFO of ALU commands with drop counting; head fields are forced to zero when empty.
module alu_cmd_queue
    import alu_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DROP_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ALU_W-1:0]         in_A,
    input  logic [ALU_W-1:0]         in_B,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic                     in_Cin,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ALU_W-1:0]         A,
    output logic [ALU_W-1:0]         B,
    output logic                     s2,
    output logic                     s1,
    output logic                     s0,
    output logic                     Cin,
    output logic [$clog2(DEPTH):0]   count,
    output logic [DROP_W-1:0]        drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count_q;
    logic [DROP_W-1:0] drop_q;
    logic              push;
    logic              pop;
    logic              drop;
    alu_cmd_t          wr_cmd;
    alu_cmd_t          rd_cmd;
    alu_cmd_t          head;

    // in_ready looks only at registered occupancy, so a full queue never accepts even while popping.
    assign in_ready  = (count_q < FULL_CNT);
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign drop      = in_valid & ~in_ready;

    assign wr_cmd = '{A: in_A, B: in_B, sel: in_sel, Cin: in_Cin};

    alu_cmd_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push & ~reset),
        .waddr (wr_ptr),
        .wdata (wr_cmd),
        .raddr (rd_ptr),
        .rdata (rd_cmd)
    );

    // Pointers are AW bits wide and wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            drop_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
            if (drop && (drop_q != '1)) begin
                drop_q <= drop_q + 1'b1;
            end
        end
    end

    assign head     = out_valid ? rd_cmd : '0;
    assign A        = head.A;
    assign B        = head.B;
    assign s2       = head.sel[2];
    assign s1       = head.sel[1];
    assign s0       = head.sel[0];
    assign Cin      = head.Cin;
    assign count    = count_q;
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_alu_cmd_queue.sv
// Self-checking bench for alu_cmd_queue: directed scenarios plus random traffic against a queue model.
module tb_alu_cmd_queue;
    import alu_pkg::*;

    localparam int DEPTH    = 4;
    localparam int DROP_W   = 8;
    localparam int DROP_MAX = 255;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_A = '0;
    logic [3:0] in_B = '0;
    logic [2:0] in_sel = '0;
    logic       in_Cin = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] A;
    logic [3:0] B;
    logic       s2, s1, s0, Cin;
    logic [2:0] count;
    logic [7:0] drop_cnt;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    alu_cmd_t mq[$];
    int       mdrop = 0;
    bit       m_full, m_pop;

    alu_cmd_queue #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_A      (in_A),
        .in_B      (in_B),
        .in_sel    (in_sel),
        .in_Cin    (in_Cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .A         (A),
        .B         (B),
        .s2        (s2),
        .s1        (s1),
        .s0        (s0),
        .Cin       (Cin),
        .count     (count),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of accepted commands and a saturating drop tally.
    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            mdrop = 0;
        end else begin
            m_full = (mq.size() == DEPTH);
            m_pop  = (mq.size() != 0) && out_ready;
            if (m_pop) void'(mq.pop_front());
            if (in_valid && !m_full) mq.push_back('{A: in_A, B: in_B, sel: in_sel, Cin: in_Cin});
            if (in_valid && m_full && mdrop < DROP_MAX) mdrop++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [11:0] exp_head;
            exp_head = (mq.size() != 0) ? {mq[0].A, mq[0].B, mq[0].sel, mq[0].Cin} : 12'h0;
            check("m_out_valid", out_valid, (mq.size() != 0));
            check("m_in_ready", in_ready, (mq.size() < DEPTH));
            check("m_count", count, mq.size());
            check("m_drop_cnt", drop_cnt, mdrop);
            check("m_head", {A, B, s2, s1, s0, Cin}, exp_head);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [3:0] a, input logic [3:0] b,
                         input logic [2:0] sel, input logic cin, input logic ordy);
        in_valid  = iv;
        in_A      = a;
        in_B      = b;
        in_sel    = sel;
        in_Cin    = cin;
        out_ready = ordy;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 4'd0, 4'd0, 3'd0, 1'b0, 1'b0);
        step();
        reset = 1'b0;
    endtask

    initial begin
        do_reset();
        step();
        chk_en = 1'b1;
        check("rst_count", count, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_head_zero", {A, B, s2, s1, s0, Cin}, 0);

        // Scenario 1: single push visible the cycle after.
        drive(1'b1, 4'd3, 4'd5, 3'b010, 1'b1, 1'b0);
        step();
        drive(1'b0, 4'd0, 4'd0, 3'd0, 1'b0, 1'b0);
        check("s1_out_valid", out_valid, 1);
        check("s1_A", A, 3);
        check("s1_B", B, 5);
        check("s1_sel", {s2, s1, s0}, 3'b010);
        check("s1_Cin", Cin, 1);
        check("s1_count", count, 1);

        // Scenario 2: fill, then one dropped push.
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 4'(i), 4'(i + 8), 3'(i), 1'(i), 1'b0);
            step();
        end
        check("s2_count_full", count, 4);
        check("s2_in_ready", in_ready, 0);
        drive(1'b1, 4'd5, 4'd13, 3'd5, 1'b1, 1'b0);
        step();
        check("s2_drop", drop_cnt, 1);
        check("s2_count_hold", count, 4);

        // Scenario 3: drain in order.
        drive(1'b0, 4'd0, 4'd0, 3'd0, 1'b0, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            check("s3_order", A, i);
            step();
        end
        check("s3_empty", out_valid, 0);
        check("s3_zero", {A, B, s2, s1, s0, Cin}, 0);

        // Scenario 4: steady push+pop at count 2 across pointer wrap.
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 4'(9 + i), 4'd1, 3'd7, 1'b0, 1'b0);
            step();
        end
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 4'(11 + k), 4'd2, 3'd1, 1'b1, 1'b1);
            check("s4_head", A, 9 + k);
            check("s4_count", count, 2);
            step();
        end
        drive(1'b0, 4'd0, 4'd0, 3'd0, 1'b0, 1'b0);
        check("s4_count_end", count, 2);
        check("s4_head_end", A, 15);

        // Scenario 5: reset wins over simultaneous push and pop.
        drive(1'b1, 4'd6, 4'd6, 3'd6, 1'b0, 1'b0);
        step();
        check("s5_count3", count, 3);
        drive(1'b1, 4'd7, 4'd7, 3'd7, 1'b1, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        drive(1'b0, 4'd0, 4'd0, 3'd0, 1'b0, 1'b0);
        check("s5_count", count, 0);
        check("s5_out_valid", out_valid, 0);
        check("s5_drop", drop_cnt, 0);
        check("s5_in_ready", in_ready, 1);

        // Scenario 6: drop counter saturation.
        drive(1'b1, 4'd1, 4'd2, 3'd3, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH + DROP_MAX; i++) step();
        check("s6_drop_max", drop_cnt, DROP_MAX);
        check("s6_count", count, 4);
        step();
        check("s6_drop_sat", drop_cnt, DROP_MAX);

        // Random traffic with occasional resets.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom),
                  3'($urandom), 1'($urandom), 1'($urandom_range(0, 1)));
            reset = ($urandom_range(0, 99) == 0);
            step();
        end
        reset = 1'b0;
        drive(1'b0, 4'd0, 4'd0, 3'd0, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH + 1; i++) step();
        check("end_empty", out_valid, 0);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_cmd_queue.md
ALU_CMD_QUEUE -- requirements
Module: alu_cmd_queue

Interface
REQ-001 Parameter DEPTH, default 4: number of command entries; SHALL be a power of two and at least 2.
REQ-002 Parameter DROP_W, default 8: width of the drop counter.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 in_valid  input  1  upstream command present.
REQ-006 in_ready  output  1  queue can accept a command this cycle.
REQ-007 in_A, in_B  input  4 each  ALU operands.
REQ-008 in_sel  input  3  opcode {s2,s1,s0}.
REQ-009 in_Cin  input  1  carry-in.
REQ-010 out_valid  output  1  head command is presented to the ALU.
REQ-011 out_ready  input  1  ALU stage consumes the head command this cycle.
REQ-012 A, B  output  4 each  head operands, wired to the ALU A and B ports.
REQ-013 s2, s1, s0, Cin  output  1 each  head opcode bits and carry-in, wired to the ALU ports of the same names.
REQ-014 count  output  $clog2(DEPTH)+1  number of stored entries.
REQ-015 drop_cnt  output  DROP_W  number of rejected commands.

Function
REQ-016 A push SHALL occur when in_valid=1 and in_ready=1; a pop SHALL occur when out_valid=1 and out_ready=1.
REQ-017 in_ready SHALL equal (count < DEPTH); it SHALL be combinational from registered state only, with no dependence on out_ready (no full-queue pass-through).
REQ-018 out_valid SHALL equal (count != 0).
REQ-019 A, B, s2, s1, s0 and Cin SHALL show the head entry fields while out_valid=1 and SHALL be all-zero while out_valid=0.
REQ-020 Latency: a command pushed at edge N SHALL appear on the outputs after edge N when the queue was empty before that edge; there SHALL be no same-cycle bypass.
REQ-021 Ordering SHALL be strict FIFO, and each command SHALL be issued exactly once.
REQ-022 Write and read pointers SHALL wrap from DEPTH-1 to 0.
REQ-023 count SHALL change by +1 on a push only, by -1 on a pop only, and stay unchanged on a simultaneous push and pop.
REQ-024 Full (count=DEPTH) with a pop: in_ready=0, so no push occurs that cycle; count SHALL fall to DEPTH-1.
REQ-025 Empty (count=0) with a push: no pop is possible; count SHALL become 1.
REQ-026 in_valid=1 with in_ready=0 SHALL discard the command and increment drop_cnt.
REQ-027 drop_cnt SHALL saturate at all-ones.
REQ-028 Storage contents SHALL change only on a push.

Reset
REQ-029 While reset=1 at an edge, count, both pointers and drop_cnt SHALL become 0.
REQ-030 The same reset edge SHALL drive out_valid=0, all ALU-side outputs to 0 and in_ready=1.
REQ-031 Reset SHALL take priority over a simultaneous push, pop or drop.
REQ-032 Reset mid-operation SHALL flush all pending commands without issuing them.
REQ-033 Storage array contents need not be cleared on reset.

Structure
REQ-034 Package alu_pkg SHALL hold ALU_W=4, SEL_W=3, and typedef alu_cmd_t {A[3:0], B[3:0], sel[2:0], Cin}.
REQ-035 Sub-module alu_cmd_mem SHALL hold the storage array: DEPTH x alu_cmd_t, one write port, one asynchronous read port.
REQ-036 alu_cmd_queue SHALL contain the pointers, count and drop logic, and the output zeroing.

Verification
REQ-037 Scenario 1: after reset, push A=3, B=5, sel=3'b010, Cin=1 with out_ready=0 -> next cycle out_valid=1, A=3, B=5, s2..s0=010, Cin=1, count=1.
REQ-038 Scenario 2: push 4 commands A=1..4 with out_ready=0 -> count=4, in_ready=0; a 5th push -> drop_cnt=1, count stays 4.
REQ-039 Scenario 3: with the queue full, set out_ready=1 for 4 cycles -> A outputs 1,2,3,4 in order, then out_valid=0 and A/B/s*/Cin all 0.
REQ-040 Scenario 4: hold count=2 and assert push and pop together for 6 cycles -> count stays 2, order preserved, pointers wrap with no loss.
REQ-041 Scenario 5: with 3 entries queued, assert reset together with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, drop_cnt=0, in_ready=1.
REQ-042 Scenario 6: force 255 drops -> drop_cnt=255; one more drop -> drop_cnt stays 255.
